// File: rtl/memoria_seq_ctrl.sv
// memoria_seq_ctrl: sequence RAM controller for the memory game (append, playback, check).
// Define TIMEOUT_EN to add a player-move timeout while waiting in CHK_WAIT.
module memoria_seq_ctrl #(
    parameter int HOLD_CYCLES    = 4,
    parameter int TIMEOUT_CYCLES = 1000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       clear,
    input  logic       cmd_append,
    input  logic [3:0] append_data,
    input  logic       cmd_play,
    input  logic       cmd_check,
    input  logic [3:0] jogada,
    input  logic       jogada_valid,
    output logic       busy,
    output logic [4:0] length,
    output logic       full,
    output logic [3:0] play_data,
    output logic       play_valid,
    output logic       fim_sequencia,
    output logic       acertou,
    output logic       errou,
    output logic       err_full,
    output logic       timeout,
    output logic       ram_we,
    output logic [3:0] ram_addr,
    output logic [3:0] ram_data,
    input  logic [3:0] ram_q
);
    typedef enum logic [2:0] {IDLE, APPEND, PLAY_RD, PLAY_SHOW, CHK_WAIT, CHK_RD, CHK_CMP} state_t;
    localparam int HW = HOLD_CYCLES > 1 ? $clog2(HOLD_CYCLES) : 1;
    state_t state;
    logic [3:0] idx, data_r, move_r, show_r;
    logic [HW-1:0] hold;
    logic last, tmo;
    assign last = {1'b0, idx} == length - 5'd1;
    assign busy = state != IDLE;
    assign full = length == 5'd16;
    assign play_valid = state == PLAY_SHOW;
    // ram_q only becomes valid in the first PLAY_SHOW cycle, so forward it until captured
    assign play_data = (play_valid && hold == '0) ? ram_q : show_r;
    assign ram_we = state == APPEND;
    assign ram_addr = ram_we ? length[3:0] : idx;
    assign ram_data = data_r;
`ifdef TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] tcnt;
    assign tmo = tcnt == TW'(TIMEOUT_CYCLES - 1);
    always_ff @(posedge clock)
        tcnt <= (reset || state != CHK_WAIT) ? '0 : tcnt + TW'(1);
`else
    assign tmo = 1'b0;
`endif
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
            length <= '0;
            idx <= '0;
            hold <= '0;
            data_r <= '0;
            move_r <= '0;
            show_r <= '0;
            fim_sequencia <= 1'b0;
            acertou <= 1'b0;
            errou <= 1'b0;
            err_full <= 1'b0;
            timeout <= 1'b0;
        end else begin
            fim_sequencia <= 1'b0;
            acertou <= 1'b0;
            errou <= 1'b0;
            err_full <= 1'b0;
            timeout <= 1'b0;
            case (state)
                IDLE:
                    if (clear) length <= '0;
                    else if (cmd_append) begin
                        if (full) err_full <= 1'b1;
                        else begin
                            data_r <= append_data;
                            state <= APPEND;
                        end
                    end else if (cmd_play) begin
                        idx <= '0;
                        if (length == '0) fim_sequencia <= 1'b1;
                        else state <= PLAY_RD;
                    end else if (cmd_check) begin
                        idx <= '0;
                        if (length == '0) acertou <= 1'b1;
                        else state <= CHK_WAIT;
                    end
                APPEND: begin
                    length <= length + 5'd1;
                    state <= IDLE;
                end
                PLAY_RD: begin
                    hold <= '0;
                    state <= PLAY_SHOW;
                end
                PLAY_SHOW: begin
                    if (hold == '0) show_r <= ram_q;
                    if (hold == HW'(HOLD_CYCLES - 1)) begin
                        if (last) begin
                            fim_sequencia <= 1'b1;
                            state <= IDLE;
                        end else begin
                            idx <= idx + 4'd1;
                            state <= PLAY_RD;
                        end
                    end else hold <= hold + HW'(1);
                end
                CHK_WAIT:
                    if (jogada_valid) begin
                        move_r <= jogada;
                        state <= CHK_RD;
                    end else if (tmo) begin
                        timeout <= 1'b1;
                        state <= IDLE;
                    end
                CHK_RD: state <= CHK_CMP;
                CHK_CMP:
                    if (ram_q != move_r) begin
                        errou <= 1'b1;
                        state <= IDLE;
                    end else if (last) begin
                        acertou <= 1'b1;
                        state <= IDLE;
                    end else begin
                        idx <= idx + 4'd1;
                        state <= CHK_WAIT;
                    end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_memoria_seq_ctrl.sv
// tb_memoria_seq_ctrl: directed bench for memoria_seq_ctrl with a behavioural 16x4 sync RAM.
module tb_memoria_seq_ctrl;
    logic clock = 1'b0;
    logic reset = 1'b1;
    logic clear = 1'b0, cmd_append = 1'b0, cmd_play = 1'b0, cmd_check = 1'b0, jogada_valid = 1'b0;
    logic [3:0] append_data = '0, jogada = '0;
    logic busy, full, play_valid, fim_sequencia, acertou, errou, err_full, timeout, ram_we;
    logic [4:0] length;
    logic [3:0] play_data, ram_addr, ram_data, ram_q;
    logic [3:0] mem [16];
    int checks = 0, failures = 0, exp_len = 0;

    memoria_seq_ctrl #(.HOLD_CYCLES(4), .TIMEOUT_CYCLES(10)) dut (
        .clock(clock), .reset(reset), .clear(clear), .cmd_append(cmd_append),
        .append_data(append_data), .cmd_play(cmd_play), .cmd_check(cmd_check),
        .jogada(jogada), .jogada_valid(jogada_valid), .busy(busy), .length(length),
        .full(full), .play_data(play_data), .play_valid(play_valid),
        .fim_sequencia(fim_sequencia), .acertou(acertou), .errou(errou),
        .err_full(err_full), .timeout(timeout), .ram_we(ram_we), .ram_addr(ram_addr),
        .ram_data(ram_data), .ram_q(ram_q)
    );

    always #5 clock = ~clock;

    always @(posedge clock) begin
        if (ram_we) mem[ram_addr] <= ram_data;
        ram_q <= mem[ram_addr];
    end

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    function automatic logic [7:0] pulses;
        return {3'b0, fim_sequencia, acertou, errou, err_full, timeout};
    endfunction

    task automatic do_append(input logic [3:0] v);
        cmd_append = 1'b1;
        append_data = v;
        tick;
        cmd_append = 1'b0;
        check("app_busy", busy, 1);
        check("app_we", ram_we, 1);
        check("app_addr", ram_addr, 8'(exp_len));
        check("app_data", ram_data, v);
        tick;
        exp_len++;
        check("app_done", busy, 0);
        check("app_we_off", ram_we, 0);
        check("app_len", length, 8'(exp_len));
    endtask

    task automatic move(input logic [3:0] m);
        jogada = m;
        jogada_valid = 1'b1;
        tick;
        jogada_valid = 1'b0;
        tick;
        tick;
    endtask

    initial begin
        logic [3:0] seq [3];
        seq[0] = 4'h3;
        seq[1] = 4'hA;
        seq[2] = 4'h5;
        for (int i = 0; i < 16; i++) mem[i] = 4'h0;
        tick;
        tick;
        reset = 1'b0;
        check("rst_busy", busy, 0);
        check("rst_len", length, 0);
        check("rst_full", full, 0);
        check("rst_pv", play_valid, 0);
        check("rst_pd", play_data, 0);
        check("rst_we", ram_we, 0);
        check("rst_addr", ram_addr, 0);
        check("rst_data", ram_data, 0);
        check("rst_pulses", pulses(), 0);

        for (int i = 0; i < 3; i++) do_append(seq[i]);

        // playback 3, A, 5
        cmd_play = 1'b1;
        tick;
        cmd_play = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("play_gap", play_valid, 0);
            check("play_gap_busy", busy, 1);
            check("play_gap_fim", fim_sequencia, 0);
            tick;
            for (int h = 0; h < 4; h++) begin
                check("play_valid", play_valid, 1);
                check("play_data", play_data, seq[i]);
                tick;
            end
        end
        check("play_fim", pulses(), 8'h10);
        check("play_busy_end", busy, 0);
        check("play_pv_end", play_valid, 0);
        tick;
        check("play_fim_once", fim_sequencia, 0);

        // check moves 3, A, 5
        cmd_check = 1'b1;
        tick;
        cmd_check = 1'b0;
        check("chk_busy", busy, 1);
        move(4'h3);
        check("chk_mid1", pulses(), 0);
        check("chk_mid1_busy", busy, 1);
        move(4'hA);
        check("chk_mid2", pulses(), 0);
        move(4'h5);
        check("chk_ok", pulses(), 8'h08);
        check("chk_ok_busy", busy, 0);
        tick;
        check("chk_ok_once", acertou, 0);

        // check moves 3, 7 -> mismatch on second
        cmd_check = 1'b1;
        tick;
        cmd_check = 1'b0;
`ifndef TIMEOUT_EN
        for (int i = 0; i < 15; i++) tick;
        check("wait_no_tmo", timeout, 0);
        check("wait_busy", busy, 1);
`endif
        move(4'h3);
        check("chk_bad_mid", pulses(), 0);
        move(4'h7);
        check("chk_bad", pulses(), 8'h04);
        check("chk_bad_busy", busy, 0);
        tick;
        check("chk_bad_once", errou, 0);

`ifdef TIMEOUT_EN
        cmd_check = 1'b1;
        tick;
        cmd_check = 1'b0;
        for (int i = 0; i < 10; i++) begin
            check("tmo_wait", timeout, 0);
            check("tmo_busy", busy, 1);
            tick;
        end
        check("tmo_pulse", pulses(), 8'h01);
        check("tmo_idle", busy, 0);
        tick;
        check("tmo_once", timeout, 0);
`endif

        // fill to 16 then overflow
        clear = 1'b1;
        tick;
        clear = 1'b0;
        exp_len = 0;
        check("clr_len", length, 0);
        for (int i = 0; i < 16; i++) do_append(4'(i) ^ 4'h5);
        check("full", full, 1);
        check("full_len", length, 16);
        cmd_append = 1'b1;
        append_data = 4'hF;
        tick;
        cmd_append = 1'b0;
        check("errfull", pulses(), 8'h02);
        check("errfull_we", ram_we, 0);
        check("errfull_busy", busy, 0);
        check("errfull_len", length, 16);
        tick;
        check("errfull_once", err_full, 0);
        check("errfull_len2", length, 16);

        clear = 1'b1;
        tick;
        clear = 1'b0;
        check("clr2_len", length, 0);
        check("clr2_full", full, 0);
        cmd_play = 1'b1;
        tick;
        cmd_play = 1'b0;
        check("empty_play", pulses(), 8'h10);
        check("empty_busy", busy, 0);

        // append and play together: append wins
        cmd_append = 1'b1;
        cmd_play = 1'b1;
        append_data = 4'h9;
        tick;
        cmd_append = 1'b0;
        cmd_play = 1'b0;
        check("prio_we", ram_we, 1);
        check("prio_addr", ram_addr, 0);
        tick;
        check("prio_len", length, 1);
        check("prio_busy", busy, 0);
        tick;
        check("prio_no_play", {play_valid, busy, fim_sequencia}, 0);

        // reset during PLAY_SHOW
        cmd_play = 1'b1;
        tick;
        cmd_play = 1'b0;
        tick;
        check("show_pv", play_valid, 1);
        check("show_pd", play_data, 4'h9);
        reset = 1'b1;
        tick;
        reset = 1'b0;
        check("mid_rst_busy", busy, 0);
        check("mid_rst_pv", play_valid, 0);
        check("mid_rst_pd", play_data, 0);
        check("mid_rst_len", length, 0);
        check("mid_rst_pulses", pulses(), 0);
        check("mid_rst_ram", {ram_we, ram_addr, ram_data}, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end
endmodule
